// File: rtl/phase_sequencer.sv
// phase_sequencer: instruction-cycle sequencer driven by the one-hot
// Phase0..Phase3 lines of the ring counter. It owns PC and IR, issues
// registered one-cycle strobes (ALU_En, Acc_Load, Mem_Write) and flags
// phase lines that are not one-hot or arrive out of order.
//
// Dbg_State = {mode[1:0], expected_phase[1:0]}
//   mode encoding: 0 IDLE, 1 RUN, 2 HALT, 3 ERR.
module phase_sequencer #(
    parameter int PC_W  = 6,
    parameter int CNT_W = 8
) (
    input  logic             Phase_Count,
    input  logic             Clear,
    input  logic             Phase0,
    input  logic             Phase1,
    input  logic             Phase2,
    input  logic             Phase3,
    input  logic             Run,
    input  logic [7:0]       Instr_In,
    output logic [PC_W-1:0]  PC,
    output logic [7:0]       IR,
    output logic             ALU_En,
    output logic             Acc_Load,
    output logic             Mem_Write,
    output logic             Halted,
    output logic             Phase_Error,
    output logic [CNT_W-1:0] Instr_Count,
    output logic [3:0]       Dbg_State
);

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_RUN  = 2'd1,
        MODE_HALT = 2'd2,
        MODE_ERR  = 2'd3
    } mode_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_ALU   = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;
    localparam logic [1:0] OP_JMP   = 2'b11;

    mode_t            mode_q, mode_d;
    logic [1:0]       exp_q, exp_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [7:0]       ir_q, ir_d;
    logic             alu_en_q, alu_en_d;
    logic             acc_load_q, acc_load_d;
    logic             mem_write_q, mem_write_d;
    logic             halted_q, halted_d;
    logic             perr_q, perr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       phase_vec;
    logic             one_hot;
    logic [1:0]       phase_idx;
    logic [1:0]       opcode;
    logic             op_is_halt;

    // Classify the phase lines: one-hot or not, and which phase is active.
    always_comb begin
        phase_vec  = {Phase3, Phase2, Phase1, Phase0};
        one_hot    = 1'b0;
        phase_idx  = 2'd0;
        case (phase_vec)
            4'b0001: begin one_hot = 1'b1; phase_idx = 2'd0; end
            4'b0010: begin one_hot = 1'b1; phase_idx = 2'd1; end
            4'b0100: begin one_hot = 1'b1; phase_idx = 2'd2; end
            4'b1000: begin one_hot = 1'b1; phase_idx = 2'd3; end
            default: begin one_hot = 1'b0; phase_idx = 2'd0; end
        endcase
        opcode     = ir_q[7:6];
        op_is_halt = (ir_q[7:6] == OP_JMP) && (ir_q[5:0] == 6'd0);
    end

    // State register: Clear dominates and drops any pending strobe.
    always_ff @(posedge Phase_Count) begin
        if (Clear) begin
            mode_q      <= MODE_IDLE;
            exp_q       <= 2'd0;
            pc_q        <= '0;
            ir_q        <= '0;
            alu_en_q    <= 1'b0;
            acc_load_q  <= 1'b0;
            mem_write_q <= 1'b0;
            halted_q    <= 1'b0;
            perr_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            mode_q      <= mode_d;
            exp_q       <= exp_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            alu_en_q    <= alu_en_d;
            acc_load_q  <= acc_load_d;
            mem_write_q <= mem_write_d;
            halted_q    <= halted_d;
            perr_q      <= perr_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state: hold by default, strobes default low so each lasts one cycle.
    always_comb begin
        mode_d      = mode_q;
        exp_d       = exp_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        alu_en_d    = 1'b0;
        acc_load_d  = 1'b0;
        mem_write_d = 1'b0;
        halted_d    = halted_q;
        perr_d      = perr_q;
        cnt_d       = cnt_q;

        case (mode_q)
            MODE_IDLE: begin
                if (phase_vec == 4'b0000) begin
                    // stall
                end else if (!one_hot) begin
                    perr_d = 1'b1;
                    mode_d = MODE_ERR;
                end else if (Run && (phase_idx == 2'd0)) begin
                    ir_d   = Instr_In;
                    pc_d   = pc_q + PC_W'(1);
                    exp_d  = 2'd1;
                    mode_d = MODE_RUN;
                end
                // Run=1 with another phase: wait for Phase0 to align.
            end

            MODE_RUN: begin
                if (phase_vec == 4'b0000) begin
                    // stall
                end else if (!one_hot || (phase_idx != exp_q)) begin
                    perr_d = 1'b1;
                    mode_d = MODE_ERR;
                end else begin
                    case (exp_q)
                        2'd0: begin
                            ir_d  = Instr_In;
                            pc_d  = pc_q + PC_W'(1);
                            exp_d = 2'd1;
                        end
                        2'd1: begin
                            if (op_is_halt) begin
                                halted_d = 1'b1;
                                mode_d   = MODE_HALT;
                            end else begin
                                exp_d = 2'd2;
                            end
                        end
                        2'd2: begin
                            alu_en_d = (opcode == OP_ALU);
                            exp_d    = 2'd3;
                        end
                        default: begin
                            acc_load_d  = (opcode == OP_ALU);
                            mem_write_d = (opcode == OP_STORE);
                            // HALT never reaches writeback, so opcode 11 here is JMP.
                            if (opcode == OP_JMP) begin
                                pc_d = PC_W'(ir_q[5:0]);
                            end
                            cnt_d = cnt_q + CNT_W'(1);
                            exp_d = 2'd0;
                            if (!Run) begin
                                mode_d = MODE_IDLE;
                            end
                        end
                    endcase
                end
            end

            // HALT and ERR freeze everything until Clear.
            default: begin
            end
        endcase

        if (opcode == OP_NOP) begin
            // NOP issues no strobes; nothing further to decode.
        end
    end

    // Outputs are taken straight from registers.
    always_comb begin
        PC          = pc_q;
        IR          = ir_q;
        ALU_En      = alu_en_q;
        Acc_Load    = acc_load_q;
        Mem_Write   = mem_write_q;
        Halted      = halted_q;
        Phase_Error = perr_q;
        Instr_Count = cnt_q;
        Dbg_State   = {mode_q, exp_q};
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer. Each step drives the phase lines,
// pushes the expected post-edge output vector into a queue, and pops and
// compares it on the following falling edge.
// Vector layout: {dbg[3:0], pc[5:0], ir[7:0], alu, acc, mw, halt, err, cnt[7:0]}
module tb_phase_sequencer;

    localparam int PC_W  = 6;
    localparam int CNT_W = 8;
    localparam int VW    = 31;

    logic             clk;
    logic             clear;
    logic             ph0, ph1, ph2, ph3;
    logic             run;
    logic [7:0]       instr;
    logic [PC_W-1:0]  pc;
    logic [7:0]       ir;
    logic             alu_en, acc_load, mem_write, halted, phase_error;
    logic [CNT_W-1:0] instr_count;
    logic [3:0]       dbg_state;

    logic [7:0]       rom [64];
    logic [VW-1:0]    exp_q [$];
    string            tag_q [$];
    int               checks;
    int               errors;

    phase_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .Phase_Count (clk),
        .Clear       (clear),
        .Phase0      (ph0),
        .Phase1      (ph1),
        .Phase2      (ph2),
        .Phase3      (ph3),
        .Run         (run),
        .Instr_In    (instr),
        .PC          (pc),
        .IR          (ir),
        .ALU_En      (alu_en),
        .Acc_Load    (acc_load),
        .Mem_Write   (mem_write),
        .Halted      (halted),
        .Phase_Error (phase_error),
        .Instr_Count (instr_count),
        .Dbg_State   (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous ROM addressed by PC
    assign instr = rom[pc];

    function automatic logic [VW-1:0] mk(input logic [3:0] dbg, input logic [5:0] p,
                                         input logic [7:0] i, input logic a,
                                         input logic ac, input logic mw, input logic h,
                                         input logic e, input logic [7:0] c);
        return {dbg, p, i, a, ac, mw, h, e, c};
    endfunction

    // Drive one cycle of inputs, queue the expectation, check after the edge.
    task automatic step(input logic clr, input logic [3:0] p, input logic r,
                        input logic [VW-1:0] exp_v, input string tag);
        logic [VW-1:0] obs;
        logic [VW-1:0] want;
        string         t;
        clear = clr;
        {ph3, ph2, ph1, ph0} = p;
        run = r;
        exp_q.push_back(exp_v);
        tag_q.push_back(tag);
        @(posedge clk);
        @(negedge clk);
        obs  = {dbg_state, pc, ir, alu_en, acc_load, mem_write, halted, phase_error, instr_count};
        want = exp_q.pop_front();
        t    = tag_q.pop_front();
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", t, obs, want);
        end
    endtask

    task automatic load_rom(input logic [7:0] a0, input logic [7:0] a5,
                            input logic [7:0] a6, input logic [7:0] a7,
                            input logic [7:0] a63);
        for (int k = 0; k < 64; k++) rom[k] = 8'h00;
        rom[0]  = a0;
        rom[5]  = a5;
        rom[6]  = a6;
        rom[7]  = a7;
        rom[63] = a63;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear = 1'b1;
        {ph3, ph2, ph1, ph0} = 4'b0000;
        run = 1'b0;
        load_rom(8'h41, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);

        // Reset and idle stall
        step(1, 4'b0000, 0, mk(4'h0, 0, 8'h00, 0,0,0,0,0, 0), "reset");
        for (int k = 0; k < 3; k++)
            step(0, 4'b0000, 0, mk(4'h0, 0, 8'h00, 0,0,0,0,0, 0), "idle_stall");

        // ALU instruction
        step(0, 4'b0001, 1, mk(4'h5, 1, 8'h41, 0,0,0,0,0, 0), "alu_fetch");
        step(0, 4'b0010, 1, mk(4'h6, 1, 8'h41, 0,0,0,0,0, 0), "alu_decode");
        step(0, 4'b0100, 1, mk(4'h7, 1, 8'h41, 1,0,0,0,0, 0), "alu_exec");
        step(0, 4'b1000, 1, mk(4'h4, 1, 8'h41, 0,1,0,0,0, 1), "alu_wb");
        step(0, 4'b0000, 1, mk(4'h4, 1, 8'h41, 0,0,0,0,0, 1), "run_stall");

        // JMP 5, STORE at 5, NOP at 6 with Run dropped, realign, fetch at 7
        load_rom(8'hC5, 8'h8A, 8'h00, 8'h41, 8'h00);
        step(1, 4'b0000, 1, mk(4'h0, 0, 8'h00, 0,0,0,0,0, 0), "clear2");
        step(0, 4'b0001, 1, mk(4'h5, 1, 8'hC5, 0,0,0,0,0, 0), "jmp_fetch");
        step(0, 4'b0010, 1, mk(4'h6, 1, 8'hC5, 0,0,0,0,0, 0), "jmp_decode");
        step(0, 4'b0100, 1, mk(4'h7, 1, 8'hC5, 0,0,0,0,0, 0), "jmp_exec");
        step(0, 4'b1000, 1, mk(4'h4, 5, 8'hC5, 0,0,0,0,0, 1), "jmp_wb");
        step(0, 4'b0001, 1, mk(4'h5, 6, 8'h8A, 0,0,0,0,0, 1), "st_fetch");
        step(0, 4'b0010, 1, mk(4'h6, 6, 8'h8A, 0,0,0,0,0, 1), "st_decode");
        step(0, 4'b0100, 1, mk(4'h7, 6, 8'h8A, 0,0,0,0,0, 1), "st_exec");
        step(0, 4'b1000, 1, mk(4'h4, 6, 8'h8A, 0,0,1,0,0, 2), "st_wb");
        step(0, 4'b0001, 1, mk(4'h5, 7, 8'h00, 0,0,0,0,0, 2), "nop_fetch");
        step(0, 4'b0010, 0, mk(4'h6, 7, 8'h00, 0,0,0,0,0, 2), "nop_decode_norun");
        step(0, 4'b0100, 0, mk(4'h7, 7, 8'h00, 0,0,0,0,0, 2), "nop_exec_norun");
        step(0, 4'b1000, 0, mk(4'h0, 7, 8'h00, 0,0,0,0,0, 3), "nop_wb_to_idle");
        step(0, 4'b0001, 0, mk(4'h0, 7, 8'h00, 0,0,0,0,0, 3), "idle_norun_hold");
        step(0, 4'b0100, 1, mk(4'h0, 7, 8'h00, 0,0,0,0,0, 3), "idle_align_wait");
        step(0, 4'b0001, 1, mk(4'h5, 8, 8'h41, 0,0,0,0,0, 3), "idle_restart");

        // PC wrap: JMP 63 then NOP at 63
        load_rom(8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
        step(1, 4'b0000, 1, mk(4'h0, 0, 8'h00, 0,0,0,0,0, 0), "clear3");
        step(0, 4'b0001, 1, mk(4'h5, 1,  8'hFF, 0,0,0,0,0, 0), "j63_fetch");
        step(0, 4'b0010, 1, mk(4'h6, 1,  8'hFF, 0,0,0,0,0, 0), "j63_decode");
        step(0, 4'b0100, 1, mk(4'h7, 1,  8'hFF, 0,0,0,0,0, 0), "j63_exec");
        step(0, 4'b1000, 1, mk(4'h4, 63, 8'hFF, 0,0,0,0,0, 1), "j63_wb");
        step(0, 4'b0001, 1, mk(4'h5, 0,  8'h00, 0,0,0,0,0, 1), "wrap_fetch");
        step(0, 4'b0010, 1, mk(4'h6, 0,  8'h00, 0,0,0,0,0, 1), "wrap_decode");
        step(0, 4'b0100, 1, mk(4'h7, 0,  8'h00, 0,0,0,0,0, 1), "wrap_exec");
        step(0, 4'b1000, 1, mk(4'h4, 0,  8'h00, 0,0,0,0,0, 2), "wrap_wb");

        // Out-of-order phase error, then recovery by Clear
        load_rom(8'h41, 8'h00, 8'h00, 8'h00, 8'h00);
        step(1, 4'b0000, 1, mk(4'h0, 0, 8'h00, 0,0,0,0,0, 0), "clear4");
        step(0, 4'b0001, 1, mk(4'h5, 1, 8'h41, 0,0,0,0,0, 0), "err_fetch");
        step(0, 4'b0010, 1, mk(4'h6, 1, 8'h41, 0,0,0,0,0, 0), "err_decode");
        step(0, 4'b1000, 1, mk(4'hE, 1, 8'h41, 0,0,0,0,1, 0), "err_skip");
        step(0, 4'b0100, 1, mk(4'hE, 1, 8'h41, 0,0,0,0,1, 0), "err_hold_p2");
        step(0, 4'b1000, 1, mk(4'hE, 1, 8'h41, 0,0,0,0,1, 0), "err_hold_p3");
        step(0, 4'b0001, 1, mk(4'hE, 1, 8'h41, 0,0,0,0,1, 0), "err_hold_p0");
        step(1, 4'b0001, 1, mk(4'h0, 0, 8'h00, 0,0,0,0,0, 0), "err_clear");
        step(0, 4'b0011, 0, mk(4'hC, 0, 8'h00, 0,0,0,0,1, 0), "idle_not_onehot");
        step(1, 4'b0000, 0, mk(4'h0, 0, 8'h00, 0,0,0,0,0, 0), "clear5");

        // HALT instruction
        load_rom(8'hC0, 8'h00, 8'h00, 8'h00, 8'h00);
        step(0, 4'b0001, 1, mk(4'h5, 1, 8'hC0, 0,0,0,0,0, 0), "halt_fetch");
        step(0, 4'b0010, 1, mk(4'h9, 1, 8'hC0, 0,0,0,1,0, 0), "halt_decode");
        step(0, 4'b0100, 1, mk(4'h9, 1, 8'hC0, 0,0,0,1,0, 0), "halt_p2");
        step(0, 4'b1000, 1, mk(4'h9, 1, 8'hC0, 0,0,0,1,0, 0), "halt_p3");
        step(0, 4'b0001, 1, mk(4'h9, 1, 8'hC0, 0,0,0,1,0, 0), "halt_p0");
        step(1, 4'b0000, 0, mk(4'h0, 0, 8'h00, 0,0,0,0,0, 0), "halt_clear");

        // Clear mid-instruction suppresses the pending ALU strobe
        load_rom(8'h41, 8'h00, 8'h00, 8'h00, 8'h00);
        step(0, 4'b0001, 1, mk(4'h5, 1, 8'h41, 0,0,0,0,0, 0), "mid_fetch");
        step(0, 4'b0010, 1, mk(4'h6, 1, 8'h41, 0,0,0,0,0, 0), "mid_decode");
        step(1, 4'b0100, 1, mk(4'h0, 0, 8'h00, 0,0,0,0,0, 0), "mid_clear");
        step(0, 4'b0000, 1, mk(4'h0, 0, 8'h00, 0,0,0,0,0, 0), "mid_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Instruction-cycle sequencer for the microprocessor, directly downstream of the 4-phase ring counter. It consumes the one-hot Phase0..Phase3 lines and turns them into fetch/decode/execute/writeback control: it owns the PC and IR and issues registered one-cycle strobes to the ALU, accumulator and data memory. It also checks that phases arrive one-hot and in order, and flags violations.

Parameters:
PC_W, 6, program counter width; instruction memory is 2^PC_W words.
CNT_W, 8, retired-instruction counter width.

Ports:
Phase_Count  input  1  system clock, rising edge; same clock as the ring counter.
Clear  input  1  synchronous reset, active-high.
Phase0  input  1  fetch phase from the ring counter.
Phase1  input  1  decode phase.
Phase2  input  1  execute phase.
Phase3  input  1  writeback phase.
Run  input  1  start/continue execution.
Instr_In  input  8  instruction word from asynchronous ROM addressed by PC; [7:6] opcode, [5:0] operand.
PC  output  PC_W  program counter, registered.
IR  output  8  instruction register, registered.
ALU_En  output  1  execute strobe.
Acc_Load  output  1  accumulator write strobe.
Mem_Write  output  1  data memory write strobe.
Halted  output  1  sticky halt flag.
Phase_Error  output  1  sticky phase-sequence error flag.
Instr_Count  output  CNT_W  retired instructions, wraps.

Behaviour:
- Clock and reset: one clock, Phase_Count. Reset is synchronous and active-high on Clear. Clear dominates all other inputs.
- Reset values: PC=0, IR=0, ALU_En=Acc_Load=Mem_Write=0, Halted=0, Phase_Error=0, Instr_Count=0. Mode=IDLE, expected phase=0.
- Phase vector: P={Phase3,Phase2,Phase1,Phase0}, sampled on each rising edge.
- Modes: IDLE, RUN, HALT, ERR. An expected-phase register E (0..3) is used in RUN.
- Strobes are registered. A strobe is high for exactly the one cycle after the edge that sampled its phase; otherwise it is 0. Latency is 1 cycle.
- Opcodes:
  - 00 NOP.
  - 01 ALU op: ALU_En in execute, Acc_Load in writeback.
  - 10 STORE: Mem_Write in writeback.
  - 11 with operand !=0: JMP.
  - 11 with operand ==0: HALT.
- IDLE:
  - Run=0: hold.
  - Run=1 and P=0001: perform the fetch action, enter RUN with E=1.
  - Run=1 and any other one-hot P: wait to align, no error.
  - Non-one-hot, non-zero P: ERR.
- RUN actions per phase, taken when P is one-hot and equals expected phase E:
  - Phase0: IR<=Instr_In; PC<=PC+1 mod 2^PC_W; E<=1.
  - Phase1: decode. HALT opcode: Halted<=1, mode<=HALT, no further strobes, PC unchanged. Otherwise E<=2.
  - Phase2: ALU_En<=1 if opcode 01; E<=3.
  - Phase3: Acc_Load<=1 (01); Mem_Write<=1 (10); JMP loads PC<=IR[5:0] zero-extended, overriding the fetch increment. Instr_Count<=Instr_Count+1 (wraps). E<=0. If Run=0, mode<=IDLE.
- P=0000 in any mode: stall. No state change, no strobes.
- Error: P not one-hot, or one-hot but not equal to E, while in RUN → Phase_Error<=1, mode<=ERR, no strobes issued on that edge. ERR holds all state until Clear.
- Run deasserted mid-instruction: the current instruction completes through Phase3, then the block enters IDLE.
- HALT and ERR ignore Phase and Run; only Clear exits. Halted and Phase_Error never both set.
- Clear mid-instruction: the next cycle shows all reset values, and any pending strobe is suppressed.

Test Plan:
- Clear=1 one cycle, then P=0000 for 3 cycles → all outputs 0, mode IDLE.
- Run=1, ROM[0]=0x41 (ALU), phases 0001,0010,0100,1000 → IR=0x41, PC=1; ALU_En high the cycle after Phase2; Acc_Load high the cycle after Phase3; Instr_Count=1.
- ROM[0]=0xC5 (JMP 5) one full cycle, then Phase0 → PC=5 after writeback; next fetch loads ROM[5] and PC=6.
- PC=2^PC_W-1 (63), NOP cycle → PC wraps to 0 after fetch, no strobes.
- In RUN with E=2, apply P=1000 → Phase_Error=1 next cycle, no strobes; further valid phases are ignored until Clear=1, after which all outputs return to 0.
- ROM[0]=0xC0 (HALT) → Halted=1 after Phase1; PC stays at 1; Instr_Count stays 0; subsequent phases produce no strobes.
